// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared state encoding and constants for the step controller
`timescale 1ns/1ps
package proc_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        RUN   = 2'b10,
        HALT  = 2'b11
    } state_e;

    function automatic logic is_halt(input logic [5:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchronizer, stability filter and press-edge detector for an active-low key
`timescale 1ns/1ps
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic GClock,
    input  logic GReset,
    input  logic KeyRaw,
    output logic KeyLevel,
    output logic PressEvent
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = KeyRaw;
        sync2_d = sync1_q;
        level_d = level_q;
        prev_d  = level_q;
        press_d = prev_q & ~level_q;
        cnt_d   = '0;
        // Level follows only after DEBOUNCE_CYCLES consecutive disagreeing samples
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge GClock or posedge GReset) begin
        if (GReset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign KeyLevel   = level_q;
    assign PressEvent = press_q;

endmodule

// File: rtl/proc_step_controller.sv
// rtl/proc_step_controller.sv - gated processor clock/reset generator with single-step, free-run and halt detection
`timescale 1ns/1ps
module proc_step_controller import proc_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int PULSE_W         = 4,
    parameter int CNT_W           = 16
) (
    input  logic               GClock,
    input  logic               GReset,
    input  logic               StepKey,
    input  logic               RunSw,
    input  logic [31:0]        InstructionIn,
    output logic               ProcClock,
    output logic               ProcResetBar,
    output logic [CNT_W-1:0]   CycleCount,
    output logic               Halted,
    output logic [STATE_W-1:0] StateOut
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int PC_W  = $clog2(2 * PULSE_W) + 1;

    logic key_level;
    logic press_event;
    logic unused_bits;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .GClock     (GClock),
        .GReset     (GReset),
        .KeyRaw     (StepKey),
        .KeyLevel   (key_level),
        .PressEvent (press_event)
    );

    assign unused_bits = ^{InstructionIn[25:0], key_level};

    state_e            state_q, state_d;
    logic              ret_run_q, ret_run_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic              proc_clk_q, proc_clk_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rst_sh_q, rst_sh_d;
    logic              rstb_q, rstb_d;
    logic              fire, run_tick, div_term;

    always_comb begin
        state_d    = state_q;
        ret_run_d  = ret_run_q;
        div_d      = div_q;
        pcnt_d     = pcnt_q;
        proc_clk_d = proc_clk_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        rst_sh_d   = 1'b1;
        rstb_d     = rst_sh_q;
        fire       = 1'b0;
        run_tick   = 1'b0;
        div_term   = (div_q == DIV_W'(RUN_DIV - 1));

        unique case (state_q)
            IDLE: begin
                if (rstb_q) begin
                    if (RunSw) begin
                        state_d = RUN;
                        div_d   = '0;
                    end else if (press_event) begin
                        fire      = 1'b1;
                        ret_run_d = 1'b0;
                    end
                end
            end
            RUN: begin
                run_tick = 1'b1;
                if (!RunSw) begin
                    state_d = IDLE;
                end else if (div_term) begin
                    fire      = 1'b1;
                    ret_run_d = 1'b1;
                end
            end
            PULSE: begin
                run_tick = ret_run_q;
                pcnt_d   = pcnt_q + 1'b1;
                if (pcnt_q == PC_W'(PULSE_W - 1)) begin
                    proc_clk_d = 1'b0;
                end
                // End of the low phase behaves like a RUN cycle so back-to-back pulses stay on period
                if (pcnt_q == PC_W'(2 * PULSE_W - 1)) begin
                    if (!ret_run_q || !RunSw) begin
                        state_d = IDLE;
                    end else if (div_term) begin
                        fire = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
            end
        endcase

        if (run_tick) begin
            div_d = div_term ? '0 : div_q + 1'b1;
        end

        if (fire) begin
            if (is_halt(InstructionIn[31:26])) begin
                state_d    = HALT;
                halted_d   = 1'b1;
                proc_clk_d = 1'b0;
            end else begin
                state_d    = PULSE;
                pcnt_d     = '0;
                proc_clk_d = 1'b1;
                cnt_d      = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge GClock or posedge GReset) begin
        if (GReset) begin
            state_q    <= IDLE;
            ret_run_q  <= 1'b0;
            div_q      <= '0;
            pcnt_q     <= '0;
            proc_clk_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
            rst_sh_q   <= 1'b0;
            rstb_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_run_q  <= ret_run_d;
            div_q      <= div_d;
            pcnt_q     <= pcnt_d;
            proc_clk_q <= proc_clk_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
            rst_sh_q   <= rst_sh_d;
            rstb_q     <= rstb_d;
        end
    end

    assign ProcClock    = proc_clk_q;
    assign ProcResetBar = rstb_q;
    assign CycleCount   = cnt_q;
    assign Halted       = halted_q;
    assign StateOut     = state_q;

endmodule

// File: tb/tb_proc_step_controller.sv
// tb/tb_proc_step_controller.sv - self-checking bench with a behavioural model of the step controller
`timescale 1ns/1ps
module tb_proc_step_controller;

    localparam int D = 8, RD = 20, PW = 2, CW = 4;

    logic          clk = 0, rst = 0, key = 1, run_sw = 0;
    logic [31:0]   instr = 32'h0;
    logic          proc_clk, rstb, halted;
    logic [CW-1:0] cyc_cnt;
    logic [1:0]    st;

    int errors = 0, checks = 0;

    proc_step_controller #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD), .PULSE_W(PW), .CNT_W(CW)) dut (
        .GClock(clk), .GReset(rst), .StepKey(key), .RunSw(run_sw), .InstructionIn(instr),
        .ProcClock(proc_clk), .ProcResetBar(rstb), .CycleCount(cyc_cnt),
        .Halted(halted), .StateOut(st)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: timers and flags derived from the textual rules
    bit hist[$];
    bit fellq[$];
    bit lvl = 1, m_halt = 0, m_run = 0;
    int rb_age = 0, m_pos = -1, m_timer = 0, m_cnt = 0;

    function automatic bit key_at(int i);
        return (i < hist.size()) ? hist[i] : 1'b1;
    endfunction

    task automatic fire();
        if (instr[31:26] == 6'h3F) m_halt = 1;
        else begin m_pos = 0; m_cnt++; end
    endtask

    task automatic run_decide();
        if (!run_sw) m_run = 0;
        else if (m_timer == RD) begin m_timer = 0; fire(); end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete(); fellq.delete();
            lvl = 1; m_halt = 0; m_run = 0; rb_age = 0; m_pos = -1; m_timer = 0; m_cnt = 0;
        end else begin
            bit stable, fell, press, active;
            hist.push_front(key);
            if (hist.size() > D + 2) void'(hist.pop_back());
            stable = 1;
            for (int i = 2; i <= D + 1; i++) if (key_at(i) == lvl) stable = 0;
            fell = stable && lvl;
            if (stable) lvl = !lvl;
            fellq.push_front(fell);
            if (fellq.size() > 3) void'(fellq.pop_back());
            press = (fellq.size() > 2) && fellq[2];
            active = (rb_age >= 2);
            if (rb_age < 2) rb_age++;
            if (!m_halt) begin
                if (m_pos >= 0) begin
                    if (m_run) m_timer++;
                    m_pos++;
                    if (m_pos == 2 * PW) begin
                        m_pos = -1;
                        if (m_run) run_decide();
                    end
                end else if (m_run) begin
                    m_timer++;
                    run_decide();
                end else if (active) begin
                    if (run_sw) begin m_run = 1; m_timer = 0; end
                    else if (press) fire();
                end
            end
        end
    end

    int edge_no = 0;
    int rises[$];
    int high_cnt = 0;
    bit prev_pc = 0;

    always @(posedge clk) edge_no++;

    always @(negedge clk) begin
        int exp_st;
        exp_st = m_halt ? 3 : (m_pos >= 0) ? 1 : m_run ? 2 : 0;
        check("ProcClock", proc_clk, (m_pos >= 0 && m_pos < PW));
        check("ProcResetBar", rstb, (rb_age >= 2));
        check("CycleCount", cyc_cnt, m_cnt % 16);
        check("Halted", halted, m_halt);
        check("StateOut", st, exp_st);
        if (proc_clk === 1'b1) high_cnt++;
        if (proc_clk === 1'b1 && !prev_pc) rises.push_back(edge_no);
        prev_pc = (proc_clk === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, n0, h0, e0;
        #1 rst = 1;
        #1;
        check("rst ProcClock", proc_clk, 0);
        check("rst ProcResetBar", rstb, 0);
        check("rst CycleCount", cyc_cnt, 0);
        check("rst Halted", halted, 0);
        check("rst StateOut", st, 0);
        tick(3);
        rst = 0;
        tick(1);
        check("resetbar edge1", rstb, 0);
        tick(1);
        check("resetbar edge2", rstb, 1);

        // Bouncing key gives exactly one pulse
        h0 = high_cnt;
        for (int i = 0; i < 10; i++) begin key = ~key; tick(3); end
        key = 0;
        tick(40);
        check("bounce count", cyc_cnt, 1);
        check("bounce width", high_cnt - h0, 2);
        key = 1;
        tick(40);
        check("release no pulse", cyc_cnt, 1);

        // Reset in the middle of a pulse
        key = 0;
        for (int i = 0; i < 40 && proc_clk !== 1'b1; i++) tick(1);
        check("midpulse reached", proc_clk, 1);
        #2 rst = 1;
        #1;
        check("midpulse ProcClock", proc_clk, 0);
        check("midpulse CycleCount", cyc_cnt, 0);
        check("midpulse ProcResetBar", rstb, 0);
        check("midpulse StateOut", st, 0);
        key = 1;
        tick(1);
        rst = 0;
        tick(1);
        check("rerelease edge1", rstb, 0);
        tick(1);
        check("rerelease edge2", rstb, 1);
        tick(30);

        // Free run and drop mid-pulse
        c0 = cyc_cnt; n0 = rises.size();
        run_sw = 1;
        e0 = edge_no + 1;
        tick(101);
        run_sw = 0;
        h0 = high_cnt;
        tick(10);
        check("run pulses", rises.size() - n0, 5);
        if (rises.size() - n0 >= 5) begin
            check("run first", rises[n0] - e0, 20);
            check("run spacing", rises[n0 + 4] - rises[n0], 80);
        end
        check("run count", (cyc_cnt - c0) % 16, 5);
        check("drop width", high_cnt - h0, 2);
        check("drop state", st, 0);

        // Halt before the third run pulse
        c0 = cyc_cnt; n0 = rises.size();
        run_sw = 1;
        for (int i = 0; i < 100 && rises.size() < n0 + 2; i++) tick(1);
        check("halt setup", rises.size() - n0, 2);
        instr = 32'hFC000000;
        tick(40);
        check("halt pulses", rises.size() - n0, 2);
        check("halt Halted", halted, 1);
        check("halt StateOut", st, 3);
        key = 0; tick(20); key = 1; tick(20);
        run_sw = 0; tick(5); run_sw = 1; tick(5); run_sw = 0; tick(5);
        check("halt sticky", st, 3);
        check("halt count", (cyc_cnt - c0) % 16, 2);
        instr = 32'h0;
        rst = 1; tick(1); rst = 0; tick(3);
        check("unhalt", halted, 0);

        // Counter wrap after 17 presses
        for (int i = 0; i < 17; i++) begin key = 0; tick(15); key = 1; tick(15); end
        tick(10);
        check("wrap count", cyc_cnt, 1);

        // Press and RunSw rising on the same cycle
        c0 = cyc_cnt; h0 = high_cnt;
        key = 0;
        tick(11);
        run_sw = 1;
        tick(1);
        check("prio state", st, 2);
        tick(5);
        check("prio no pulse", high_cnt - h0, 0);
        check("prio count", cyc_cnt, c0);
        key = 1; run_sw = 0;
        tick(20);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) key = ~key;
            if ($urandom_range(0, 79) == 0) run_sw = ~run_sw;
            instr = $urandom;
            if ($urandom_range(0, 9) == 0) instr[31:26] = 6'h3F;
            if (halted && $urandom_range(0, 19) == 0) begin
                rst = 1; tick(1); rst = 0;
            end
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
